// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls, multicycle HI/LO decode hold.
// Forwarding and stall outputs are combinational from inputs and state; only the sequencer and stall counter are registered.
module hazard_ctrl #(
   parameter int MD_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic [4:0]  rse,
   input  logic [4:0]  rte,
   input  logic [4:0]  rf_wae,
   input  logic [4:0]  rf_wam,
   input  logic [4:0]  rf_waw,
   input  logic        we_rege,
   input  logic        we_regm,
   input  logic        we_regw,
   input  logic [1:0]  dm2rege,
   input  logic [1:0]  dm2regm,
   input  logic        branch_d,
   input  logic        jr_d,
   input  logic        md_start_d,
   input  logic        stat_clr,
   output logic        stall_f,
   output logic        stall_d,
   output logic        flush_e,
   output logic        forward_ad,
   output logic        forward_bd,
   output logic [1:0]  forward_ae,
   output logic [1:0]  forward_be,
   output logic        md_busy,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam logic [4:0] CNT_LOAD = 5'(MD_LAT - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic lw_stall;
   logic br_stall;
   logic br_op;
   logic br_match_e;
   logic br_match_m;
   logic haz;
   logic md_hold;
   logic stall;

   // Execute operands: the newer result in M wins over W.
   always_comb begin
      forward_ae = 2'b00;
      if (rse != 5'd0 && we_regm && rse == rf_wam)
         forward_ae = 2'b10;
      else if (rse != 5'd0 && we_regw && rse == rf_waw)
         forward_ae = 2'b01;

      forward_be = 2'b00;
      if (rte != 5'd0 && we_regm && rte == rf_wam)
         forward_be = 2'b10;
      else if (rte != 5'd0 && we_regw && rte == rf_waw)
         forward_be = 2'b01;
   end

   assign forward_ad = (rs_d != 5'd0) && we_regm && (rs_d == rf_wam);
   assign forward_bd = (rt_d != 5'd0) && we_regm && (rt_d == rf_wam);

   assign lw_stall = (dm2rege == 2'b01) && we_rege && (rf_wae != 5'd0) &&
                     ((rf_wae == rs_d) || (rf_wae == rt_d));

   // A register jump only reads rs, so rt matches count for branches alone.
   assign br_op      = branch_d | jr_d;
   assign br_match_e = (rf_wae == rs_d) || (branch_d && (rf_wae == rt_d));
   assign br_match_m = (rf_wam == rs_d) || (branch_d && (rf_wam == rt_d));
   assign br_stall   = (br_op && we_rege && (rf_wae != 5'd0) && br_match_e) ||
                       (br_op && (dm2regm == 2'b01) && (rf_wam != 5'd0) && br_match_m);

   assign haz = lw_stall | br_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Hazards seen while BUSY are covered by the hold already and leave the count alone.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (md_start_d && !haz) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1)
               state_d = S_RELEASE;
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   always_comb begin
      md_hold = 1'b0;
      md_busy = 1'b0;
      case (state_q)
         S_IDLE:    md_hold = md_start_d;
         S_BUSY: begin
            md_hold = 1'b1;
            md_busy = 1'b1;
         end
         S_RELEASE: md_busy = 1'b1;
         default: begin
            md_hold = 1'b0;
            md_busy = 1'b0;
         end
      endcase
   end

   assign stall   = haz | md_hold;
   assign stall_f = stall;
   assign stall_d = stall;
   assign flush_e = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stat_clr)
         stall_cnt_d = 16'd0;
      else if (stall && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, range 2..32: decode-hold cycles for a multicycle multiply/divide.
REQ-002 SHALL have ports, clock and reset first (name direction width meaning):
- clk in 1: sole clock; all state updates on rising edge.
- rst in 1: synchronous, active-low reset.
- rs_d, rt_d in 5: source registers of the decode instruction.
- rse, rte in 5: source registers of the execute instruction.
- rf_wae, rf_wam, rf_waw in 5: destination register in E, M, W.
- we_rege, we_regm, we_regw in 1: register-write enable in E, M, W.
- dm2rege, dm2regm in 2: writeback select in E, M; 2'b01 = load.
- branch_d, jr_d in 1: decode instruction is a branch, or a register jump.
- md_start_d in 1: decode instruction is a multicycle HI/LO op.
- stat_clr in 1: clears the stall counter.
- stall_f, stall_d, flush_e out 1: fetch hold, decode hold, execute bubble.
- forward_ad, forward_bd out 1: decode comparator operand from alu_outm.
- forward_ae, forward_be out 2: execute operand select; 00 = register file, 01 = wd_rf, 10 = alu_outm.
- md_busy out 1: multicycle sequencer not IDLE.
- stall_cnt out 16: saturating count of stalled cycles.

Function
REQ-003 SHALL compute forward_ae as follows; forward_be is identical with rte:
- 10 if rse!=0, we_regm=1 and rse==rf_wam;
- else 01 if rse!=0, we_regw=1 and rse==rf_waw;
- else 00.
- M SHALL take priority over W when both match.
REQ-004 SHALL assert forward_ad when rs_d!=0, we_regm=1 and rs_d==rf_wam; forward_bd likewise with rt_d.
REQ-005 SHALL assert lw_stall when dm2rege==01, we_rege=1, rf_wae!=0 and rf_wae equals rs_d or rt_d.
REQ-006 SHALL assert br_stall in either case below (rt_d compared only for branch_d):
- (branch_d|jr_d), we_rege=1, rf_wae!=0 and rf_wae matches rs_d/rt_d;
- (branch_d|jr_d), dm2regm==01, rf_wam!=0 and rf_wam matches rs_d/rt_d.
REQ-007 SHALL define haz = lw_stall | br_stall, combinational.
REQ-008 SHALL implement a 3-state sequencer IDLE/BUSY/RELEASE with a 5-bit down-counter cnt.
REQ-009 In IDLE with md_start_d=1 and haz=0, SHALL go to BUSY and load cnt=MD_LAT-1; in IDLE with md_start_d=1 and haz=1, SHALL stay IDLE.
REQ-010 In BUSY SHALL decrement cnt each cycle; when cnt==1, SHALL go to RELEASE.
REQ-011 In RELEASE SHALL ignore md_start_d, which is the same instruction leaving decode, and go to IDLE next cycle.
REQ-012 SHALL define md_hold = (IDLE & md_start_d) | BUSY; md_hold SHALL be 0 in RELEASE.
REQ-013 SHALL drive stall_f = stall_d = flush_e = haz | md_hold; each multicycle op therefore holds decode exactly MD_LAT consecutive cycles when haz=0.
REQ-014 SHALL assert md_busy in BUSY and RELEASE.
REQ-015 SHALL increment stall_cnt each cycle stall_d=1, saturating at 16'hFFFF.
REQ-016 stat_clr=1 SHALL load stall_cnt=0 and take priority over increment.
REQ-017 haz arising during BUSY SHALL NOT alter cnt or state.
REQ-018 Forwarding and stall outputs SHALL be combinational from inputs and state, with no added latency.

Reset
REQ-019 rst=0 at a clock edge SHALL set state=IDLE, cnt=0, stall_cnt=0; this includes reset mid-BUSY, with no resumption after release.
REQ-020 During and after reset, with md_start_d=0 and no hazard, outputs SHALL be: stall_f/stall_d/flush_e=0, md_busy=0, stall_cnt=0.
REQ-021 Reset SHALL NOT gate the forwarding outputs, which remain pure functions of inputs.

Verification
REQ-022 Bench SHALL cover:
- Forwarding: rse=rf_wam=rf_waw=5, we_regm=we_regw=1 -> forward_ae=10; set we_regm=0 -> 01; set rse=0 -> 00.
- Load-use: dm2rege=01, we_rege=1, rf_wae=8, rt_d=8 -> stall_f=stall_d=flush_e=1 that cycle; stall_cnt +1.
- Branch: branch_d=1, rs_d=9, we_rege=1, rf_wae=9 -> stall=1; jr_d=1, rt_d=9, rs_d=3 -> stall=0.
- Multicycle op, MD_LAT=4: md_start_d held high -> stall_d high exactly 4 cycles, md_busy high cycles 2-5, IDLE after; stall_cnt=4.
- Reset mid-BUSY: rst=0 during 2nd BUSY cycle -> next cycle state IDLE, md_busy=0, stall_cnt=0.
- Saturation: preload 16'hFFFE, hold stall 3 cycles -> 16'hFFFF; stat_clr with stall_d=1 -> 0.
